// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and saturation limits for the MAC accumulate pipeline
// Purpose: stage-1 payload type and the signed/unsigned clamp limits.
// Contents:
//   PROD_MAX_W    width of the product field; the product is held already extended
//   s1_payload_t  stage-1 register contents {product, last, mode, valid}
//   sat_lim_t     clamp limits held as PROD_MAX_W+1-bit two's-complement values
//   sat_limits()  max/min clamp limits for a given accumulator width and mode
package mac_pkg;

  localparam int unsigned PROD_MAX_W = 64;

  typedef struct packed {
    logic [PROD_MAX_W-1:0] product;
    logic                  last;
    logic                  mode;
    logic                  valid;
  } s1_payload_t;

  typedef struct packed {
    logic [PROD_MAX_W:0] max_v;
    logic [PROD_MAX_W:0] min_v;
  } sat_lim_t;

  // Callers slice [acc_w:0]. Signed min is ~max, which is -2^(acc_w-1).
  function automatic sat_lim_t sat_limits(input logic mode, input int unsigned acc_w);
    sat_lim_t lim;
    if (mode) begin
      lim.max_v = ((PROD_MAX_W+1)'(1) << (acc_w - 1)) - (PROD_MAX_W+1)'(1);
      lim.min_v = ~lim.max_v;
    end else begin
      lim.max_v = ((PROD_MAX_W+1)'(1) << acc_w) - (PROD_MAX_W+1)'(1);
      lim.min_v = '0;
    end
    return lim;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// rtl/mac_sat_add.sv - combinational W+1-bit accumulate with clamp
// Purpose: adds an extended product to the accumulator and clamps to the mode's range.
// Ports:
//   acc_i    in  W    current accumulator value
//   addend_i in  W+1  product, already sign/zero-extended to W+1 bits
//   mode_i   in  1    1 = two's complement, 0 = unsigned
//   sum_o    out W    clamped sum
//   sat_o    out 1    a clamp was applied
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] acc_i,
  input  logic [W:0]   addend_i,
  input  logic         mode_i,
  output logic [W-1:0] sum_o,
  output logic         sat_o
);

  sat_lim_t     lim;
  logic [W:0]   max_w;
  logic [W:0]   min_w;
  logic [W:0]   acc_ext;
  logic [W:0]   raw;
  logic         unused_lim_hi;

  assign lim           = sat_limits(mode_i, W);
  assign max_w         = lim.max_v[W:0];
  assign min_w         = lim.min_v[W:0];
  assign unused_lim_hi = ^{lim.max_v[PROD_MAX_W:W+1], lim.min_v[PROD_MAX_W:W+1]};

  always_comb begin
    acc_ext = mode_i ? {acc_i[W-1], acc_i} : {1'b0, acc_i};
    raw     = acc_ext + addend_i;
    sum_o   = raw[W-1:0];
    sat_o   = 1'b0;
    if (mode_i) begin
      if ($signed(raw) > $signed(max_w)) begin
        sum_o = max_w[W-1:0];
        sat_o = 1'b1;
      end else if ($signed(raw) < $signed(min_w)) begin
        sum_o = min_w[W-1:0];
        sat_o = 1'b1;
      end
    end else if (raw > max_w) begin
      // An unsigned sum of non-negative terms can only overflow upward.
      sum_o = max_w[W-1:0];
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/mac_acc_pipe.sv
// rtl/mac_acc_pipe.sv - two-stage handshaked framed multiply-accumulate with saturation
// Purpose: stage 1 registers A*B; stage 2 accumulates it. A frame's result is
//   loaded into the output register on the edge after its last beat reaches stage 2.
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   in_valid/in_ready       operand handshake (A, B, in_last, signed_mode)
//   out_valid/out_ready     result handshake (S, count, sat)
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              in_last,
  input  logic              signed_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  S,
  output logic [CNT_W-1:0]  count,
  output logic              sat
);

  localparam int PROD_W = 2 * DATA_W;

  s1_payload_t s1_q, s1_d;
  logic        first_q, first_d;
  logic        mode_q, mode_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fsat_q, fsat_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_last_q, s2_last_d;
  logic [ACC_W-1:0] s_q, s_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic                     stall, accept, beat_mode, restart;
  logic signed [PROD_W-1:0] a_s, b_s, prod_s;
  logic        [PROD_W-1:0] a_u, b_u, prod_u;
  logic [ACC_W-1:0]         base_acc, add_sum;
  logic [CNT_W-1:0]         base_cnt;
  logic                     base_sat, add_sat;
  logic [ACC_W:0]           addend;
  logic                     unused_prod_hi;

  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  // Mode is taken from the first beat of a frame and ignored afterwards.
  assign beat_mode = first_q ? signed_mode : mode_q;

  assign a_s    = {{DATA_W{A[DATA_W-1]}}, A};
  assign b_s    = {{DATA_W{B[DATA_W-1]}}, B};
  assign prod_s = a_s * b_s;
  assign a_u    = {{DATA_W{1'b0}}, A};
  assign b_u    = {{DATA_W{1'b0}}, B};
  assign prod_u = a_u * b_u;

  // Stage 2 holds the last beat of a frame for one edge; when it moves on, the
  // accumulator restarts from zero so the next frame follows with no bubble.
  assign restart  = s2_valid_q && s2_last_q;
  assign base_acc = restart ? '0 : acc_q;
  assign base_cnt = restart ? '0 : cnt_q;
  assign base_sat = restart ? 1'b0 : fsat_q;

  assign addend         = s1_q.product[ACC_W:0];
  assign unused_prod_hi = ^s1_q.product[PROD_MAX_W-1:ACC_W+1];

  mac_sat_add #(.W(ACC_W)) u_sat_add (
    .acc_i    (base_acc),
    .addend_i (addend),
    .mode_i   (s1_q.mode),
    .sum_o    (add_sum),
    .sat_o    (add_sat)
  );

  always_comb begin
    s1_d        = s1_q;
    first_d     = first_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    fsat_d      = fsat_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    s_d         = s_q;
    count_d     = count_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (!stall) begin
      s1_d.valid   = accept;
      s1_d.last    = accept && in_last;
      s1_d.mode    = beat_mode;
      s1_d.product = beat_mode ? {{(PROD_MAX_W-PROD_W){prod_s[PROD_W-1]}}, prod_s}
                               : {{(PROD_MAX_W-PROD_W){1'b0}}, prod_u};
      if (accept) begin
        first_d = in_last;
        mode_d  = beat_mode;
      end

      if (s1_q.valid) begin
        acc_d  = add_sum;
        cnt_d  = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
        fsat_d = base_sat | add_sat;
      end else begin
        acc_d  = base_acc;
        cnt_d  = base_cnt;
        fsat_d = base_sat;
      end
      s2_valid_d = s1_q.valid;
      s2_last_d  = s1_q.valid && s1_q.last;

      if (restart) begin
        s_d         = acc_q;
        count_d     = cnt_q;
        sat_d       = fsat_q;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q        <= '0;
      first_q     <= 1'b1;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      fsat_q      <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s_q         <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      fsat_q      <= fsat_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s_q         <= s_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign count     = count_q;
  assign sat       = sat_q;

endmodule
